// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared constants and width helper for the handshaked register pipe
package reg_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;
  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction
endpackage

// File: rtl/reg_pipe_hs_if.sv
// reg_pipe_hs_if: valid/ready upstream and downstream bus of the register pipe
interface reg_pipe_hs_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
endinterface

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one bubble-collapsing handshaked register stage
module reg_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             i_prev_valid,
  input  logic [WIDTH-1:0] i_prev_data,
  input  logic             i_next_acc,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_acc
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  assign o_acc   = ~r_valid | i_next_acc;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  // valid follows the upstream stage whenever this stage can accept; flush empties it
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_valid <= 1'b0;
    else if (clr) r_valid <= 1'b0;
    else if (o_acc) r_valid <= i_prev_valid;
  // data loads only from a valid source, so an empty upstream never overwrites it
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_data <= RESET_VAL;
    else if (!clr && o_acc && i_prev_valid) r_data <= i_prev_data;
endmodule

// File: rtl/reg_pipe_hs.sv
// reg_pipe_hs: DEPTH-stage valid/ready register pipeline with flush and occupancy count
module reg_pipe_hs
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clr,
  reg_pipe_hs_if.slave               bus,
  output logic [cnt_w(DEPTH)-1:0]    count
);
  localparam int CW = cnt_w(DEPTH);
  logic             w_valid [DEPTH+1];
  logic             w_acc   [DEPTH+1];
  logic [WIDTH-1:0] w_data  [DEPTH+1];
  logic             w_out_xfer;
  logic [CW-1:0]    r_count;
  assign bus.in_ready  = w_acc[0] & ~clr;
  assign w_valid[0]    = bus.in_valid & bus.in_ready;
  assign w_data[0]     = bus.in_data;
  assign w_acc[DEPTH]  = bus.out_ready;
  assign bus.out_valid = w_valid[DEPTH];
  assign bus.out_data  = w_data[DEPTH];
  assign w_out_xfer    = w_valid[DEPTH] & bus.out_ready;
  assign count         = r_count;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    reg_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clock        (clock),
      .reset        (reset),
      .clr          (clr),
      .i_prev_valid (w_valid[i]),
      .i_prev_data  (w_data[i]),
      .i_next_acc   (w_acc[i+1]),
      .o_valid      (w_valid[i+1]),
      .o_data       (w_data[i+1]),
      .o_acc        (w_acc[i])
    );
  end
  // occupancy tracks input minus output transfers and empties on flush
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_count <= '0;
    else r_count <= clr ? '0 : r_count + CW'(w_valid[0]) - CW'(w_out_xfer);
endmodule
